fetch_decode_pipe: RTL and testbench
====================================

# fetch_decode_pipe

Stall/flush responder for the 5-stage MIPS pipeline. Holds the PC register, the IF/ID pipeline register and the ID/EX control bundle. Applies the load-use stall requests (pc_write, if_id_write, pipe_stall) issued by the hazard detection unit and the taken-branch flush from ID. Feeds id_ex_rt / id_ex_memread back to the hazard detection unit, closing the stall loop.

## Interface
- WIDTH, 32, datapath/PC/instruction width
- RESET_PC, 32'h0000_0000, PC value after reset
- CTRL_W, 10, width of decoded ID control bundle
- CNT_W, 16, width of performance counters
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- pc_write  in  1  1 = PC may update; 0 = hold PC
- if_id_write  in  1  1 = IF/ID may load; 0 = hold IF/ID
- pipe_stall  in  1  1 = insert bubble into ID/EX
- branch_taken  in  1  branch resolved taken in ID this cycle
- branch_target  in  WIDTH  branch destination address
- imem_instr  in  WIDTH  instruction fetched at pc
- id_ctrl  in  CTRL_W  decoded control bundle of instruction in ID
- id_memread  in  1  MemRead of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- pc  out  WIDTH  current fetch address
- if_id_instr  out  WIDTH  IF/ID instruction
- if_id_pc4  out  WIDTH  IF/ID PC+4
- if_id_valid  out  1  IF/ID holds a real instruction
- id_ex_ctrl  out  CTRL_W  ID/EX control bundle
- id_ex_memread  out  1  ID/EX MemRead (to hazard unit)
- id_ex_rt  out  5  ID/EX rt (to hazard unit)
- id_ex_valid  out  1  ID/EX holds a real instruction
- stall_count  out  CNT_W  cycles with pipe_stall accepted
- flush_count  out  CNT_W  taken branches accepted

## Operation
- All outputs registered; updated only on rising clk.
- Per-cycle priority: reset > stall (pipe_stall=1) > branch_taken > normal advance.
- Reset: pc=RESET_PC; if_id_instr=0 (NOP), if_id_pc4=0, if_id_valid=0; id_ex_ctrl=0, id_ex_memread=0, id_ex_rt=0, id_ex_valid=0; both counters 0. Reset mid-stall or mid-flush discards all state.
- Stall handling, each input honoured independently:
  - pc_write=0 -> pc holds; else pc advances per normal/branch rule.
  - if_id_write=0 -> if_id_instr/pc4/valid hold.
  - pipe_stall=1 -> id_ex_ctrl=0, id_ex_memread=0, id_ex_rt=0, id_ex_valid=0 (bubble); stall_count++.
- branch_taken with pipe_stall=1: branch ignored that cycle (operands not ready); the hazard unit re-presents it next cycle since the branch stays in ID.
- Branch accepted (branch_taken=1, pipe_stall=0): pc={branch_target[WIDTH-1:2],2'b00}; IF/ID flushed (instr=0, pc4=0, valid=0) regardless of if_id_write; ID/EX loads the branch normally; flush_count++.
- Normal advance: pc=pc+4 (modulo 2^WIDTH, 32'hFFFF_FFFC wraps to 0); if_id_instr=imem_instr, if_id_pc4=pc+4, if_id_valid=1; id_ex_ctrl=id_ctrl, id_ex_memread=id_memread, id_ex_rt=id_rt, id_ex_valid=if_id_valid.
- Invalid ID slot: when if_id_valid=0, ID/EX loads id_ctrl=0, memread=0, rt=0 (forced bubble), so a flushed slot cannot raise a false hazard.
- Counters saturate at 2^CNT_W-1; they do not wrap.

## Timing
- Stall: inputs sampled cycle N; PC/IF/ID hold and ID/EX bubble visible after edge N. The hazard condition clears at N+1 because id_ex_memread=0.
- Branch penalty: exactly 1 bubble. The target instruction is in IF/ID 2 edges after the branch is accepted.
- First valid if_id_valid=1 one edge after reset deasserts. First id_ex_valid=1 after two edges.
- No combinational path from any input to any output.

## Test plan
- Reset/fetch: reset 2 cycles, then release, imem_instr=0x8C010004 -> pc 0,4,8; if_id_instr=0x8C010004 and if_id_pc4=4 after the first edge; if_id_valid=1.
- Load-use stall: one cycle of pc_write=0, if_id_write=0, pipe_stall=1 at pc=8 -> pc stays 8, IF/ID unchanged, id_ex_valid=0, id_ex_memread=0, stall_count=1. Next cycle resumes with pc=12.
- Branch flush: branch_taken=1, branch_target=0x40 -> pc=0x40, if_id_valid=0, if_id_instr=0, flush_count=1. The slot then reaches ID/EX as a bubble (id_ex_valid=0). Target unaligned 0x43 -> pc=0x40.
- Stall+branch together: both asserted -> branch ignored, pc held, flush_count unchanged. Branch asserted alone the next cycle -> pc=target.
- Wrap/saturation: pc=0xFFFFFFFC advances to 0. pipe_stall held 70000 cycles -> stall_count=0xFFFF, not wrapped.
- Reset mid-stall: reset during pipe_stall=1 -> all outputs at reset values next edge, counters 0.

Source files
------------

// File: rtl/fetch_decode_pipe.sv
// fetch_decode_pipe: PC, IF/ID and ID/EX registers responding to load-use stalls and taken-branch flushes.
module fetch_decode_pipe #(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int CTRL_W = 10,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_write,
    input  logic              if_id_write,
    input  logic              pipe_stall,
    input  logic              branch_taken,
    input  logic [WIDTH-1:0]  branch_target,
    input  logic [WIDTH-1:0]  imem_instr,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_memread,
    input  logic [4:0]        id_rt,
    output logic [WIDTH-1:0]  pc,
    output logic [WIDTH-1:0]  if_id_instr,
    output logic [WIDTH-1:0]  if_id_pc4,
    output logic              if_id_valid,
    output logic [CTRL_W-1:0] id_ex_ctrl,
    output logic              id_ex_memread,
    output logic [4:0]        id_ex_rt,
    output logic              id_ex_valid,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);
    logic             accept;
    logic [WIDTH-1:0] pc_plus4;
    assign accept   = branch_taken && !pipe_stall;
    assign pc_plus4 = pc + WIDTH'(4);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= RESET_PC;
            if_id_instr   <= '0;
            if_id_pc4     <= '0;
            if_id_valid   <= 1'b0;
            id_ex_ctrl    <= '0;
            id_ex_memread <= 1'b0;
            id_ex_rt      <= '0;
            id_ex_valid   <= 1'b0;
            stall_count   <= '0;
            flush_count   <= '0;
        end else begin
            if (pc_write)
                pc <= accept ? (branch_target & ~WIDTH'(3)) : pc_plus4;
            if (accept) begin
                if_id_instr <= '0;
                if_id_pc4   <= '0;
                if_id_valid <= 1'b0;
            end else if (if_id_write) begin
                if_id_instr <= imem_instr;
                if_id_pc4   <= pc_plus4;
                if_id_valid <= 1'b1;
            end
            // an empty ID slot is forced to a bubble so it cannot raise a false hazard
            if (pipe_stall || !if_id_valid) begin
                id_ex_ctrl    <= '0;
                id_ex_memread <= 1'b0;
                id_ex_rt      <= '0;
                id_ex_valid   <= 1'b0;
            end else begin
                id_ex_ctrl    <= id_ctrl;
                id_ex_memread <= id_memread;
                id_ex_rt      <= id_rt;
                id_ex_valid   <= 1'b1;
            end
            if (pipe_stall && stall_count != '1)
                stall_count <= stall_count + CNT_W'(1);
            if (accept && flush_count != '1)
                flush_count <= flush_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_fetch_decode_pipe.sv
// tb_fetch_decode_pipe: directed table, corner sequences and random stimulus against a behavioural model.
module tb_fetch_decode_pipe;
    logic        clk = 0, reset = 1;
    logic        pc_write = 1, if_id_write = 1, pipe_stall = 0, branch_taken = 0;
    logic [31:0] branch_target = 0, imem_instr = 0;
    logic [9:0]  id_ctrl = 0;
    logic        id_memread = 0;
    logic [4:0]  id_rt = 0;
    logic [31:0] pc, if_id_instr, if_id_pc4;
    logic        if_id_valid, id_ex_memread, id_ex_valid;
    logic [9:0]  id_ex_ctrl;
    logic [4:0]  id_ex_rt;
    logic [15:0] stall_count, flush_count;

    int errors = 0, checks = 0;

    fetch_decode_pipe dut (
        .clk(clk), .reset(reset), .pc_write(pc_write), .if_id_write(if_id_write),
        .pipe_stall(pipe_stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_instr(imem_instr), .id_ctrl(id_ctrl), .id_memread(id_memread), .id_rt(id_rt),
        .pc(pc), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
        .id_ex_ctrl(id_ex_ctrl), .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
        .id_ex_valid(id_ex_valid), .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // Reference model: pipeline contents as plain variables, updated from the rules per edge
    longint m_pc, m_ii, m_ip4, m_sc, m_fc;
    int     m_iv, m_ec, m_em, m_er, m_ev;

    task automatic model_edge();
        bit take;
        if (reset) begin
            m_pc = 0; m_ii = 0; m_ip4 = 0; m_iv = 0;
            m_ec = 0; m_em = 0; m_er = 0; m_ev = 0; m_sc = 0; m_fc = 0;
            return;
        end
        take = branch_taken && !pipe_stall;
        if (pipe_stall || m_iv == 0) begin
            m_ec = 0; m_em = 0; m_er = 0; m_ev = 0;
        end else begin
            m_ec = id_ctrl; m_em = id_memread; m_er = id_rt; m_ev = 1;
        end
        if (pipe_stall) m_sc = (m_sc + 1 > 65535) ? 65535 : m_sc + 1;
        if (take) m_fc = (m_fc + 1 > 65535) ? 65535 : m_fc + 1;
        if (take) begin
            m_ii = 0; m_ip4 = 0; m_iv = 0;
        end else if (if_id_write) begin
            m_ii = imem_instr; m_ip4 = (m_pc + 4) % 64'h1_0000_0000; m_iv = 1;
        end
        if (pc_write) m_pc = take ? (branch_target / 4) * 4 : (m_pc + 4) % 64'h1_0000_0000;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("pc", pc, 32'(m_pc));
        chk("if_id_instr", if_id_instr, 32'(m_ii));
        chk("if_id_pc4", if_id_pc4, 32'(m_ip4));
        chk("if_id_valid", 32'(if_id_valid), 32'(m_iv));
        chk("id_ex_ctrl", 32'(id_ex_ctrl), 32'(m_ec));
        chk("id_ex_memread", 32'(id_ex_memread), 32'(m_em));
        chk("id_ex_rt", 32'(id_ex_rt), 32'(m_er));
        chk("id_ex_valid", 32'(id_ex_valid), 32'(m_ev));
        chk("stall_count", 32'(stall_count), 32'(m_sc));
        chk("flush_count", 32'(flush_count), 32'(m_fc));
    endtask

    task automatic step(input bit check);
        @(posedge clk);
        model_edge();
        #1;
        if (check) check_model();
    endtask

    task automatic drive(input bit pw, iw, ps, bt, input logic [31:0] tgt);
        pc_write = pw; if_id_write = iw; pipe_stall = ps; branch_taken = bt; branch_target = tgt;
    endtask

    typedef struct {
        bit pw, iw, ps, bt;
        logic [31:0] tgt, e_pc;
        bit e_iv, e_ev;
        logic [15:0] e_sc, e_fc;
    } vec_t;
    vec_t tv[9];

    initial begin
        tv[0] = '{1,1,0,0,32'h0,  32'h4,  1,0,0,0};
        tv[1] = '{1,1,0,0,32'h0,  32'h8,  1,1,0,0};
        tv[2] = '{0,0,1,0,32'h0,  32'h8,  1,0,1,0};
        tv[3] = '{1,1,0,0,32'h0,  32'hC,  1,1,1,0};
        tv[4] = '{1,1,0,1,32'h40, 32'h40, 0,1,1,1};
        tv[5] = '{1,1,0,0,32'h0,  32'h44, 1,0,1,1};
        tv[6] = '{0,0,1,1,32'h80, 32'h44, 1,0,2,1};
        tv[7] = '{1,1,0,1,32'h83, 32'h80, 0,1,2,2};
        tv[8] = '{1,1,0,0,32'h0,  32'h84, 1,0,2,2};

        id_ctrl = 10'h3A5; id_memread = 1; id_rt = 5'd7; imem_instr = 32'h8C01_0004;
        reset = 1;
        step(0); step(1);
        chk("reset_pc", pc, 32'h0);
        chk("reset_cnt", 32'(stall_count), 32'h0);
        reset = 0;
        for (int i = 0; i < 9; i++) begin
            drive(tv[i].pw, tv[i].iw, tv[i].ps, tv[i].bt, tv[i].tgt);
            step(1);
            chk($sformatf("tv%0d_pc", i), pc, tv[i].e_pc);
            chk($sformatf("tv%0d_iv", i), 32'(if_id_valid), 32'(tv[i].e_iv));
            chk($sformatf("tv%0d_ev", i), 32'(id_ex_valid), 32'(tv[i].e_ev));
            chk($sformatf("tv%0d_sc", i), 32'(stall_count), 32'(tv[i].e_sc));
            chk($sformatf("tv%0d_fc", i), 32'(flush_count), 32'(tv[i].e_fc));
            if (i == 0) begin
                chk("first_instr", if_id_instr, 32'h8C01_0004);
                chk("first_pc4", if_id_pc4, 32'h4);
            end
            if (i == 2) chk("stall_memread", 32'(id_ex_memread), 32'h0);
            if (i == 4) chk("flush_instr", if_id_instr, 32'h0);
        end

        // PC wrap at the top of the address space
        drive(1,1,0,1,32'hFFFF_FFFC); step(1);
        chk("wrap_pre", pc, 32'hFFFF_FFFC);
        drive(1,1,0,0,0); step(1);
        chk("wrap_post", pc, 32'h0);

        // Reset during a stall discards everything
        drive(0,0,1,0,0); reset = 1; step(1);
        chk("rst_stall_sc", 32'(stall_count), 32'h0);
        chk("rst_stall_iv", 32'(if_id_valid), 32'h0);
        reset = 0;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0,3) != 0, $urandom_range(0,3) != 0, $urandom_range(0,4) == 0,
                  $urandom_range(0,5) == 0, $urandom);
            imem_instr = $urandom; id_ctrl = 10'($urandom); id_memread = 1'($urandom);
            id_rt = 5'($urandom);
            reset = ($urandom_range(0,60) == 0);
            step(1);
        end
        reset = 0;

        // Stall counter saturation
        drive(0,0,1,0,0);
        for (int i = 0; i < 70000; i++) step(0);
        check_model();
        chk("stall_sat", 32'(stall_count), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
